// File: rtl/rc_pwm_pkg.sv
// Shared definitions for the RC pulse modulator/decoder pair: direction codes,
// nominal pulse widths, window length and active-count to power-level mapping.
package rc_pwm_pkg;

  typedef enum logic [1:0] {
    DIR_FWD = 2'd0,
    DIR_NEU = 2'd1,
    DIR_REV = 2'd2,
    DIR_BAD = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    WIN_IDLE    = 2'd0,
    WIN_COLLECT = 2'd1,
    WIN_EMIT    = 2'd2
  } win_state_t;

  localparam int WIDTH_BITS    = 21;
  localparam int WINDOW_FRAMES = 24;
  localparam int FRAME_BITS    = 5;

  // Minimum active-frame count for each power level; below LVL1_MIN is level 0.
  localparam logic [FRAME_BITS-1:0] LVL1_MIN = 5'd4;
  localparam logic [FRAME_BITS-1:0] LVL2_MIN = 5'd5;
  localparam logic [FRAME_BITS-1:0] LVL3_MIN = 5'd8;
  localparam logic [FRAME_BITS-1:0] LVL4_MIN = 5'd10;
  localparam logic [FRAME_BITS-1:0] LVL5_MIN = 5'd13;
  localparam logic [FRAME_BITS-1:0] LVL6_MIN = 5'd17;
  localparam logic [FRAME_BITS-1:0] LVL7_MIN = 5'd20;

  function automatic int nom_fwd(input int clk_rate);
    return clk_rate / 1000;
  endfunction

  function automatic int nom_neu(input int clk_rate);
    return (clk_rate * 3) / 2000;
  endfunction

  function automatic int nom_rev(input int clk_rate);
    return clk_rate / 500;
  endfunction

  function automatic logic [2:0] level_of(input logic [FRAME_BITS-1:0] a);
    if (a >= LVL7_MIN) return 3'd7;
    if (a >= LVL6_MIN) return 3'd6;
    if (a >= LVL5_MIN) return 3'd5;
    if (a >= LVL4_MIN) return 3'd4;
    if (a >= LVL3_MIN) return 3'd3;
    if (a >= LVL2_MIN) return 3'd2;
    if (a >= LVL1_MIN) return 3'd1;
    return 3'd0;
  endfunction

endpackage

// File: rtl/rc_pulse_decoder_if.sv
// Result bundle of the RC pulse decoder; master drives it, slave observes it.
interface rc_pulse_decoder_if;
  import rc_pwm_pkg::*;

  logic [WIDTH_BITS-1:0] WidthOut;
  logic [1:0]            DirCode;
  logic                  PulseStb;
  logic [4:0]            ModInfo;
  logic                  Valid;
  logic                  Timeout;
  logic                  Conflict;

  modport master (output WidthOut, DirCode, PulseStb, ModInfo, Valid, Timeout, Conflict);
  modport slave  (input  WidthOut, DirCode, PulseStb, ModInfo, Valid, Timeout, Conflict);
endinterface

// File: rtl/pulse_width_meter.sv
// Synchronizes the pulse line, measures each high time and classifies it.
// Strobe lands 3 cycles after the first low sample of the pin; no backpressure.
module pulse_width_meter
  import rc_pwm_pkg::*;
#(
  parameter int CLK_RATE = 100000000,
  parameter int TOL      = 10000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PulseIn,
  output logic [WIDTH_BITS-1:0] width,
  output dir_t                  dir,
  output logic                  stb,
  output logic                  rise
);

  localparam logic [WIDTH_BITS-1:0] F_LO    = WIDTH_BITS'(nom_fwd(CLK_RATE) - TOL);
  localparam logic [WIDTH_BITS-1:0] F_HI    = WIDTH_BITS'(nom_fwd(CLK_RATE) + TOL);
  localparam logic [WIDTH_BITS-1:0] N_LO    = WIDTH_BITS'(nom_neu(CLK_RATE) - TOL);
  localparam logic [WIDTH_BITS-1:0] N_HI    = WIDTH_BITS'(nom_neu(CLK_RATE) + TOL);
  localparam logic [WIDTH_BITS-1:0] R_LO    = WIDTH_BITS'(nom_rev(CLK_RATE) - TOL);
  localparam logic [WIDTH_BITS-1:0] R_HI    = WIDTH_BITS'(nom_rev(CLK_RATE) + TOL);
  localparam logic [WIDTH_BITS-1:0] CNT_MAX = {WIDTH_BITS{1'b1}};

  logic                  sync1, sync2, line_q;
  logic                  rise_d, fall_d, fall_q;
  logic                  armed;
  logic [WIDTH_BITS-1:0] cnt;

  function automatic dir_t classify(input logic [WIDTH_BITS-1:0] w);
    if (w == CNT_MAX)             return DIR_BAD;
    if (w >= F_LO && w <= F_HI)   return DIR_FWD;
    if (w >= N_LO && w <= N_HI)   return DIR_NEU;
    if (w >= R_LO && w <= R_HI)   return DIR_REV;
    return DIR_BAD;
  endfunction

  assign rise_d = sync2 & ~line_q;
  assign fall_d = ~sync2 & line_q;

  // Line history resets high so a pulse in progress at reset release never looks like a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
      rise   <= 1'b0;
      fall_q <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      width  <= '0;
      dir    <= DIR_NEU;
      stb    <= 1'b0;
    end else begin
      sync1  <= PulseIn;
      sync2  <= sync1;
      line_q <= sync2;
      rise   <= rise_d;
      fall_q <= fall_d & armed;
      armed  <= armed | rise_d;
      if (rise_d)
        cnt <= {{(WIDTH_BITS-1){1'b0}}, 1'b1};
      else if (sync2 && cnt != CNT_MAX)
        cnt <= cnt + {{(WIDTH_BITS-1){1'b0}}, 1'b1};
      stb <= fall_q;
      if (fall_q) begin
        width <= cnt;
        dir   <= classify(cnt);
      end
    end
  end

endmodule

// File: rtl/rc_pulse_decoder.sv
// Recovers the 5-bit ModInfo word from 24-frame windows of classified pulses, with line timeout.
// ModInfo/Valid follow the closing pulse strobe by 2 cycles; no backpressure.
module rc_pulse_decoder
  import rc_pwm_pkg::*;
#(
  parameter int CLK_RATE    = 100000000,
  parameter int TOL         = 10000,
  parameter int TIMEOUT_CYC = CLK_RATE / 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PulseIn,
  rc_pulse_decoder_if.master  bus
);

  localparam int                    TMO_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_BITS-1:0]   TMO_LAST = TMO_BITS'(TIMEOUT_CYC - 1);

  dir_t                  pdir;
  logic                  pstb, prise, is_act, fresh;
  logic [WIDTH_BITS-1:0] pwidth;

  win_state_t            state_q, state_d;
  logic [FRAME_BITS-1:0] frm_q, frm_d, act_q, act_d;
  logic                  saw_f_q, saw_f_d, saw_r_q, saw_r_d;
  logic [4:0]            mod_q, mod_d;
  logic                  conf_q, conf_d, valid_q, valid_d, timeout_q, timeout_d;
  logic [TMO_BITS-1:0]   tmo_q, tmo_d;

  pulse_width_meter #(.CLK_RATE(CLK_RATE), .TOL(TOL)) u_meter (
    .CLK     (CLK),
    .RST     (RST),
    .PulseIn (PulseIn),
    .width   (pwidth),
    .dir     (pdir),
    .stb     (pstb),
    .rise    (prise)
  );

  assign is_act = (pdir == DIR_FWD) || (pdir == DIR_REV);
  assign fresh  = (state_q == WIN_IDLE);

  always_comb begin
    state_d   = state_q;
    frm_d     = frm_q;
    act_d     = act_q;
    saw_f_d   = saw_f_q;
    saw_r_d   = saw_r_q;
    mod_d     = mod_q;
    conf_d    = conf_q;
    valid_d   = 1'b0;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;

    if (pstb && state_q != WIN_EMIT) begin
      frm_d   = (fresh ? '0 : frm_q) + 5'd1;
      act_d   = (fresh ? '0 : act_q) + {4'd0, is_act};
      saw_f_d = (saw_f_q & ~fresh) | (pdir == DIR_FWD);
      saw_r_d = (saw_r_q & ~fresh) | (pdir == DIR_REV);
      state_d = (frm_d == FRAME_BITS'(WINDOW_FRAMES)) ? WIN_EMIT : WIN_COLLECT;
    end

    if (state_q == WIN_EMIT) begin
      valid_d = 1'b1;
      conf_d  = saw_f_q & saw_r_q;
      mod_d   = (act_q == '0 || conf_d) ? {3'd0, DIR_NEU}
                                        : {level_of(act_q), saw_f_q ? DIR_FWD : DIR_REV};
      frm_d   = '0;
      act_d   = '0;
      saw_f_d = 1'b0;
      saw_r_d = 1'b0;
      state_d = WIN_COLLECT;
    end

    // A rise in the expiry cycle restarts the count instead of timing out.
    if (prise) begin
      tmo_d     = '0;
      timeout_d = 1'b0;
    end else if (!timeout_q) begin
      if (tmo_q == TMO_LAST) begin
        timeout_d = 1'b1;
        valid_d   = 1'b1;
        mod_d     = {3'd0, DIR_NEU};
        state_d   = WIN_IDLE;
        frm_d     = '0;
        act_d     = '0;
        saw_f_d   = 1'b0;
        saw_r_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_BITS'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= WIN_IDLE;
      frm_q     <= '0;
      act_q     <= '0;
      saw_f_q   <= 1'b0;
      saw_r_q   <= 1'b0;
      mod_q     <= 5'b00001;
      conf_q    <= 1'b0;
      valid_q   <= 1'b0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_q     <= frm_d;
      act_q     <= act_d;
      saw_f_q   <= saw_f_d;
      saw_r_q   <= saw_r_d;
      mod_q     <= mod_d;
      conf_q    <= conf_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.WidthOut = pwidth;
  assign bus.DirCode  = pdir;
  assign bus.PulseStb = pstb;
  assign bus.ModInfo  = mod_q;
  assign bus.Valid    = valid_q;
  assign bus.Timeout  = timeout_q;
  assign bus.Conflict = conf_q;

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Directed bench for rc_pulse_decoder at a scaled clock rate (F=100, N=150, R=200 cycles).
module tb_rc_pulse_decoder;
  import rc_pwm_pkg::*;

  localparam int CLK_RATE = 100000;
  localparam int TOL      = 10;
  localparam int TMO      = 1000;
  localparam int GAP      = 80;

  typedef struct {int width; logic [1:0] dir; int at;} sexp_t;
  typedef struct {logic [4:0] mod; logic conf; logic tmo; int at;} vexp_t;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  PulseIn = 1'b1;
  int    cyc = 0;
  int    n_assert = 0;
  int    n_fail = 0;
  int    last_rise = 0;
  int    last_fall = 0;
  sexp_t stbq[$];
  vexp_t vq[$];

  rc_pulse_decoder_if bus ();

  rc_pulse_decoder #(.CLK_RATE(CLK_RATE), .TOL(TOL), .TIMEOUT_CYC(TMO)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PulseIn (PulseIn),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] k);
    return (k == 2'd0) ? 100 : (k == 2'd1) ? 150 : 200;
  endfunction

  // Called on a negedge; the strobe follows the first low sample by 3 cycles.
  task automatic send(input int width, input logic [1:0] dir, input int gap);
    PulseIn   = 1'b1;
    last_rise = cyc;
    repeat (width) @(negedge CLK);
    PulseIn   = 1'b0;
    last_fall = cyc;
    stbq.push_back('{width: width, dir: dir, at: cyc + 4});
    repeat (gap) @(negedge CLK);
  endtask

  task automatic run_window(input logic [47:0] pat, input logic [4:0] mod, input logic conf);
    for (int i = 0; i < 24; i++)
      send(width_of(pat[2*i +: 2]), pat[2*i +: 2], (i == 23) ? 0 : GAP);
    vq.push_back('{mod: mod, conf: conf, tmo: 1'b0, at: last_fall + 6});
    repeat (GAP) @(negedge CLK);
  endtask

  // Internal rise is seen 4 cycles after the pin is driven; expiry follows TMO cycles later.
  task automatic expect_timeout(input logic conf);
    vq.push_back('{mod: 5'b00001, conf: conf, tmo: 1'b1, at: last_rise + TMO + 4});
    repeat (TMO + 100) @(negedge CLK);
  endtask

  always @(negedge CLK) begin : mon
    sexp_t s;
    vexp_t v;
    if (!RST) begin
      if (bus.PulseStb) begin
        chk("stb_expected", 32'(stbq.size() != 0), 32'd1);
        if (stbq.size() != 0) begin
          s = stbq.pop_front();
          chk("width_out", 32'(bus.WidthOut), s.width);
          chk("dir_code", 32'(bus.DirCode), 32'(s.dir));
          chk("stb_cycle", cyc, s.at);
        end
      end
      if (bus.Valid) begin
        chk("valid_expected", 32'(vq.size() != 0), 32'd1);
        if (vq.size() != 0) begin
          v = vq.pop_front();
          chk("mod_info", 32'(bus.ModInfo), 32'(v.mod));
          chk("conflict", 32'(bus.Conflict), 32'(v.conf));
          chk("timeout_at_valid", 32'(bus.Timeout), 32'(v.tmo));
          chk("valid_cycle", cyc, v.at);
        end
      end
    end
  end

  initial begin
    logic [47:0] pat;

    repeat (3) @(negedge CLK);
    chk("rst_width", 32'(bus.WidthOut), 32'd0);
    chk("rst_dir", 32'(bus.DirCode), 32'd1);
    chk("rst_stb", 32'(bus.PulseStb), 32'd0);
    chk("rst_modinfo", 32'(bus.ModInfo), 32'd1);
    chk("rst_valid", 32'(bus.Valid), 32'd0);
    chk("rst_timeout", 32'(bus.Timeout), 32'd0);
    chk("rst_conflict", 32'(bus.Conflict), 32'd0);

    // Line high across reset release: that pulse must not produce a strobe.
    RST = 1'b0;
    repeat (500) @(negedge CLK);
    PulseIn = 1'b0;
    repeat (50) @(negedge CLK);
    send(100, 2'd0, 0);
    expect_timeout(1'b0);

    // Inclusive tolerance bounds around neutral.
    send(140, 2'd1, 100);
    chk("timeout_cleared_by_pulse", 32'(bus.Timeout), 32'd0);
    send(139, 2'd3, 100);
    send(160, 2'd1, 100);
    send(161, 2'd3, 100);
    expect_timeout(1'b0);

    // 11 of 24 frames reverse.
    for (int i = 0; i < 24; i++)
      pat[2*i +: 2] = (((i * 11) % 24) < 11) ? 2'd2 : 2'd1;
    run_window(pat, 5'b10010, 1'b0);
    expect_timeout(1'b0);

    // A=3 forward at a shifted offset, then a fully forward window back to back.
    pat = {24{2'b01}};
    pat[2*5 +: 2]  = 2'd0;
    pat[2*14 +: 2] = 2'd0;
    pat[2*23 +: 2] = 2'd0;
    run_window(pat, 5'b00000, 1'b0);
    pat = '0;
    run_window(pat, 5'b11100, 1'b0);
    expect_timeout(1'b0);

    // Mixed directions.
    pat = {24{2'b01}};
    pat[1:0] = 2'd0;
    pat[3:2] = 2'd0;
    pat[5:4] = 2'd2;
    pat[7:6] = 2'd2;
    run_window(pat, 5'b00001, 1'b1);

    // Partial window of 10 frames abandoned by timeout; next pulse starts a fresh window.
    for (int i = 0; i < 10; i++) send(150, 2'd1, GAP);
    expect_timeout(1'b1);
    chk("timeout_level_idle", 32'(bus.Timeout), 32'd1);
    pat = {24{2'b01}};
    pat[1:0] = 2'd2;
    run_window(pat, 5'b00010, 1'b0);
    chk("timeout_level_after_pulse", 32'(bus.Timeout), 32'd0);
    expect_timeout(1'b0);

    repeat (20) @(negedge CLK);
    chk("stb_queue_drained", 32'(stbq.size()), 32'd0);
    chk("valid_queue_drained", 32'(vq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
